// File: rtl/sub_div_sequencer.sv
// sub_div_sequencer
//   Multi-cycle unsigned restoring divider controller. It drives one external
//   WIDTH-bit subtractor and runs one trial subtraction per clock. The
//   subtractor carry (1 = no borrow) selects each quotient bit.
//   Results are returned through valid/ready handshakes.
//
// Ports
//   clk, reset_n         clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready while idle)
//   dividend, divisor    operands, sampled on the input handshake
//   sub_a, sub_b         subtractor minuend / subtrahend (0 outside CALC)
//   sub_diff, sub_cf     subtractor difference and carry (1 when a >= b)
//   out_valid/out_ready  result handshake
//   quotient, remainder  results, held stable while out_valid && !out_ready
//   div_zero             result came from a zero divisor
//   busy                 sequencer not idle
module sub_div_sequencer #(
  parameter int unsigned       WIDTH   = 16,
  parameter int unsigned       CNT_W   = 5,
  parameter logic [WIDTH-1:0]  DZ_QUOT = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] sub_a,
  output logic [WIDTH-1:0] sub_b,
  input  logic [WIDTH-1:0] sub_diff,
  input  logic             sub_cf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] d_reg, q_reg, r_reg;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] trial, r_next, q_next;
  logic             take, last, accept;

  // Shift the next dividend bit into the partial remainder. If R[MSB] was
  // set, the real trial value is WIDTH+1 bits wide and certainly >= D, so
  // the subtraction is taken and the low WIDTH bits of sub_diff are exact.
  assign trial  = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
  assign take   = r_reg[WIDTH-1] | sub_cf;
  assign r_next = take ? sub_diff : trial;
  assign q_next = {q_reg[WIDTH-2:0], take};
  assign last   = (cnt == CNT_W'(WIDTH - 1));
  assign accept = in_valid && (state == IDLE);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = (divisor == '0) ? DONE : CALC;
      CALC: if (last)   state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default:          state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    sub_a     = '0;
    sub_b     = '0;
    if (state == CALC) begin
      sub_a = trial;
      sub_b = d_reg;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_reg     <= '0;
      q_reg     <= '0;
      r_reg     <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            d_reg <= divisor;
            q_reg <= dividend;
            r_reg <= '0;
            cnt   <= '0;
            if (divisor == '0) begin
              quotient  <= DZ_QUOT;
              remainder <= dividend;
              div_zero  <= 1'b1;
            end else begin
              div_zero  <= 1'b0;
            end
          end
        end
        CALC: begin
          r_reg <= r_next;
          q_reg <= q_next;
          cnt   <= cnt + CNT_W'(1);
          if (last) begin
            quotient  <= q_next;
            remainder <= r_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_div_sequencer.sv
// Directed bench for sub_div_sequencer with a behavioural 16-bit subtractor
// connected to the sub_* ports.
module tb_sub_div_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic [15:0] sub_a, sub_b, sub_diff;
  logic        sub_cf;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] quotient, remainder;
  logic        div_zero;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // 16-bit subtractor: difference mod 2^16, carry = no borrow
  assign sub_diff = sub_a - sub_b;
  assign sub_cf   = (sub_a >= sub_b);

  sub_div_sequencer #(.WIDTH(16), .CNT_W(5), .DZ_QUOT(16'hFFFF)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .sub_a(sub_a), .sub_b(sub_b), .sub_diff(sub_diff), .sub_cf(sub_cf),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one edge; returns just after the accept edge.
  task automatic start(input logic [15:0] a, input logic [15:0] b);
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid, bounded.
  task automatic wait_done(input string tag, input int exp_lat);
    int n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, n, exp_lat);
  endtask

  task automatic chk_res(input string tag, input logic [15:0] q, input logic [15:0] r,
                         input logic dz);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_quotient"}, {16'd0, quotient}, {16'd0, q});
    chk({tag, "_remainder"}, {16'd0, remainder}, {16'd0, r});
    chk({tag, "_div_zero"}, {31'd0, div_zero}, {31'd0, dz});
    chk({tag, "_in_ready_done"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_sub_a_done"}, {16'd0, sub_a}, 32'd0);
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_out_valid_after"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic div_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] q, input logic [15:0] r, input logic dz,
                        input int lat);
    start(a, b);
    wait_done(tag, lat);
    chk_res(tag, q, r, dz);
    release_result(tag);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_quotient", {16'd0, quotient}, 32'd0);
    chk("rst_remainder", {16'd0, remainder}, 32'd0);
    chk("rst_div_zero", {31'd0, div_zero}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sub_a", {16'd0, sub_a}, 32'd0);
    chk("rst_sub_b", {16'd0, sub_b}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // 100/7, also look at the first subtractor operands
    start(16'd100, 16'd7);
    chk("first_sub_b", {16'd0, sub_b}, 32'd7);
    chk("first_sub_a", {16'd0, sub_a}, 32'd0);
    chk("calc_busy", {31'd0, busy}, 32'd1);
    chk("calc_in_ready", {31'd0, in_ready}, 32'd0);
    wait_done("d100_7", 16);
    chk_res("d100_7", 16'd14, 16'd2, 1'b0);
    release_result("d100_7");

    div_op("dffff_1", 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 16);
    div_op("d5_9", 16'h0005, 16'h0009, 16'h0000, 16'h0005, 1'b0, 16);
    div_op("dffff_8001", 16'hFFFF, 16'h8001, 16'h0001, 16'h7FFE, 1'b0, 16);
    div_op("dzero", 16'h04D2, 16'h0000, 16'hFFFF, 16'h04D2, 1'b1, 0);

    // Back-pressure: hold out_ready low with new operands offered
    start(16'd100, 16'd7);
    wait_done("hold", 16);
    dividend = 16'd50;
    divisor  = 16'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_quotient", {16'd0, quotient}, 32'd14);
      chk("hold_remainder", {16'd0, remainder}, 32'd2);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    release_result("hold");

    // Reset during iteration 8 aborts the operation
    start(16'd60000, 16'd7);
    for (int i = 0; i < 8; i++) step();
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_sub_a", {16'd0, sub_a}, 32'd0);
    chk("abort_quotient", {16'd0, quotient}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("abort_idle_out_valid", {31'd0, out_valid}, 32'd0);
    div_op("d1000_33", 16'd1000, 16'd33, 16'd30, 16'd10, 1'b0, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog in case a bounded wait is bypassed
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
